trig_conditioner: RTL

Input conditioning stage that sits directly upstream of the one-shot pulse generator and drives its trigger input. It synchronises an asynchronous trigger line, debounces it, and selects which edges count. It then emits a single-cycle `trig` pulse, and enforces a programmable hold-off and a downstream-busy lockout so the one-shot is never retriggered mid-pulse. Edges rejected by the lockout are counted for diagnostics.

---
 rtl/trig_conditioner.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/trig_conditioner.sv
// Trigger input conditioner: synchroniser, debounce, edge qualification and hold-off/busy lockout
// ahead of a one-shot. Define TRIG_DROP_CNT_EN to build the dropped-edge diagnostic counter.
module trig_conditioner #(
    parameter int DB_W = 8,
    parameter int HO_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_async,
    input  logic [1:0]      edge_sel,
    input  logic [DB_W-1:0] db_len,
    input  logic [HO_W-1:0] holdoff,
    input  logic            busy,
    output logic            trig,
    output logic            level,
    output logic            locked,
    output logic [7:0]      drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic            s1_r;
    logic            s2_r;
    logic            level_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            commit_s;
    logic            rise_s;
    logic            fall_s;
    logic            qedge_s;
    state_t          state_r;
    state_t          next_state_s;
    logic [HO_W-1:0] ho_cnt_r;
    logic [HO_W-1:0] ho_cnt_next_s;
    logic            trig_r;
    logic            locked_r;

    // Two-flop synchroniser for the asynchronous trigger line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= in_async;
            s2_r <= s1_r;
        end
    end

    // >= keeps the count safe if db_len is lowered while a change is pending
    assign commit_s = (s2_r != level_r) && (db_cnt_r >= db_len);
    assign rise_s   = commit_s & s2_r;
    assign fall_s   = commit_s & ~s2_r;

    // Debounce counter and committed level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r <= {DB_W{1'b0}};
            level_r  <= 1'b0;
        end else if (s2_r == level_r) begin
            db_cnt_r <= {DB_W{1'b0}};
        end else if (commit_s) begin
            level_r  <= s2_r;
            db_cnt_r <= {DB_W{1'b0}};
        end else begin
            db_cnt_r <= db_cnt_r + DB_W'(1);
        end
    end

    // Edge qualifier selection
    always_comb begin
        qedge_s = 1'b0;
        case (edge_sel)
            2'b00:   qedge_s = rise_s;
            2'b01:   qedge_s = fall_s;
            2'b10:   qedge_s = rise_s | fall_s;
            default: qedge_s = 1'b0;
        endcase
    end

    // Lockout FSM next-state and hold-off counter update
    always_comb begin
        next_state_s  = state_r;
        ho_cnt_next_s = ho_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (qedge_s && !busy) begin
                    next_state_s = ST_FIRE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FIRE: begin
                ho_cnt_next_s = holdoff;
                if (holdoff != {HO_W{1'b0}}) begin
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                ho_cnt_next_s = ho_cnt_r - HO_W'(1);
                if (ho_cnt_r == HO_W'(1)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s  = ST_IDLE;
                ho_cnt_next_s = {HO_W{1'b0}};
            end
        endcase
    end

    // State, hold-off counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ho_cnt_r <= {HO_W{1'b0}};
            trig_r   <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            ho_cnt_r <= ho_cnt_next_s;
            trig_r   <= (next_state_s == ST_FIRE);
            locked_r <= (next_state_s != ST_IDLE);
        end
    end

    assign trig   = trig_r;
    assign level  = level_r;
    assign locked = locked_r;

`ifdef TRIG_DROP_CNT_EN
    logic       drop_s;
    logic [7:0] drop_cnt_r;

    // A qualified edge is dropped when busy in IDLE or whenever locked out
    assign drop_s = qedge_s & (busy | (state_r != ST_IDLE));

    // Saturating dropped-edge counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
